// File: rtl/rle_encoding_if.sv
// Stream handshake bundle for rle_encoding: block in, packed run/literal bytes out.
// The master drives the request and the block. The slave returns the encoded stream and its status.
interface rle_encoding_if;
    logic         Enable;
    logic [511:0] A;
    logic [511:0] C;
    logic [6:0]   len;
    logic         done;
    logic         clipped;

    modport master (output Enable, A, input C, len, done, clipped);
    modport slave  (input Enable, A, output C, len, done, clipped);
endinterface

// File: rtl/rle_encoding.sv
// Reverse zig-zag run-length encoder for one 8x8 block, one coefficient per clock.
// Optional literal clamping is enabled with the macro RLE_ENCODING_CLIP_EN.
module rle_encoding #(
    parameter logic [7:0] PAD_BYTE = 8'h80,
    parameter int         LIT_MAX  = 78,
    parameter int         LIT_MIN  = -49
) (
    input logic          Clock,
    input logic          reset,
    rle_encoding_if.slave bus
);
`ifdef RLE_ENCODING_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam logic [5:0] ZZR [64] = '{
        63, 62, 55, 47, 54, 61, 60, 53, 46, 39, 31, 38, 45, 52, 59, 58,
        51, 44, 37, 30, 23, 15, 22, 29, 36, 43, 50, 57, 56, 49, 42, 35,
        28, 21, 14,  7,  6, 13, 20, 27, 34, 41, 48, 40, 33, 26, 19, 12,
         5,  4, 11, 18, 25, 32, 24, 17, 10,  3,  2,  9, 16,  8,  1,  0
    };

    typedef enum logic [1:0] {IDLE, SCAN, OUT, HOLD} state_t;

    state_t       state, state_next;
    logic [511:0] blk, buffer, c_q;
    logic [5:0]   k, wa, wb;
    logic [6:0]   run, wp, len_q;
    logic         done_q, clipped_q;
    logic [7:0]   x, lit;
    logic         clip_hit;

    assign bus.C       = c_q;
    assign bus.len     = len_q;
    assign bus.done    = done_q;
    assign bus.clipped = clipped_q;

    assign wa = wp[5:0];
    assign wb = wp[5:0] + 6'd1;

    always_comb begin
        x        = blk[{ZZR[k], 3'b000} +: 8];
        lit      = x;
        clip_hit = 1'b0;
        if (CLIP_EN) begin
            if ($signed(x) > LIT_MAX) begin
                lit      = 8'(LIT_MAX);
                clip_hit = 1'b1;
            end else if ($signed(x) < LIT_MIN) begin
                lit      = 8'(LIT_MIN);
                clip_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.Enable) state_next = SCAN;
            SCAN: begin
                if (!bus.Enable)   state_next = IDLE;
                else if (k == 6'd63) state_next = OUT;
            end
            OUT:  state_next = HOLD;
            HOLD: if (!bus.Enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state     <= IDLE;
            c_q       <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            clipped_q <= 1'b0;
            k         <= '0;
            run       <= '0;
            wp        <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (bus.Enable) begin
                    blk       <= bus.A;
                    buffer    <= {64{PAD_BYTE}};
                    k         <= '0;
                    run       <= '0;
                    wp        <= '0;
                    clipped_q <= 1'b0;
                end
                SCAN: if (bus.Enable) begin
                    k <= k + 6'd1;
                    if (x == 8'd0) begin
                        // The trailing run is flushed on the last coefficient.
                        if (k == 6'd63) begin
                            buffer[{wa, 3'b000} +: 8] <= {1'b1, run + 7'd1};
                            wp <= wp + 7'd1;
                        end else begin
                            run <= run + 7'd1;
                        end
                    end else begin
                        if (clip_hit) clipped_q <= 1'b1;
                        if (run != 7'd0) begin
                            buffer[{wa, 3'b000} +: 8] <= {1'b1, run};
                            buffer[{wb, 3'b000} +: 8] <= {1'b0, lit[6:0]};
                            wp  <= wp + 7'd2;
                            run <= '0;
                        end else begin
                            buffer[{wa, 3'b000} +: 8] <= {1'b0, lit[6:0]};
                            wp <= wp + 7'd1;
                        end
                    end
                end
                OUT: begin
                    c_q    <= buffer;
                    len_q  <= wp;
                    done_q <= 1'b1;
                end
                HOLD: if (!bus.Enable) done_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rle_encoding.sv
// Scoreboard bench for rle_encoding: a reference encoder predicts each block's stream and latency.
module tb_rle_encoding;
    logic Clock = 1'b0;
    logic reset = 1'b0;
    rle_encoding_if bus ();

    rle_encoding dut (.Clock(Clock), .reset(reset), .bus(bus));

    always #5 Clock = ~Clock;

    typedef struct {
        logic [511:0] c;
        logic [6:0]   len;
        logic         clip;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [511:0] last_c;
    logic [6:0]   last_len;
    int           zz[64];

    function automatic void build_zigzag();
        int n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) for (int r = hi; r >= lo; r--) begin zz[n] = r * 8 + (s - r); n++; end
            else            for (int r = lo; r <= hi; r++) begin zz[n] = r * 8 + (s - r); n++; end
        end
    endfunction

    function automatic exp_t model(input logic [511:0] a);
        exp_t e;
        int n = 0, run = 0, v;
        logic signed [7:0] x;
        logic [7:0] lb;
        e.c = {64{8'h80}};
        e.clip = 1'b0;
        for (int i = 0; i < 64; i++) begin
            x = a[zz[63 - i] * 8 +: 8];
            v = x;
            if (v == 0) begin
                if (i == 63) begin e.c[n * 8 +: 8] = 8'(128 + run + 1); n++; end
                else run++;
            end else begin
`ifdef RLE_ENCODING_CLIP_EN
                if (v > 78)  begin v = 78;  e.clip = 1'b1; end
                if (v < -49) begin v = -49; e.clip = 1'b1; end
`endif
                lb = 8'(v);
                if (run > 0) begin e.c[n * 8 +: 8] = 8'(128 + run); n++; run = 0; end
                e.c[n * 8 +: 8] = {1'b0, lb[6:0]};
                n++;
            end
        end
        e.len = 7'(n);
        return e;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b = '0;
        for (int p = 0; p < 64; p++)
            if ($urandom_range(0, 3) == 0) b[p * 8 +: 8] = 8'($urandom_range(0, 127) - 49);
        return b;
    endfunction

    task automatic encode(input logic [511:0] a, input string name, input bit scramble);
        exp_t e;
        int cycles = 0;
        sb.push_back(model(a));
        @(negedge Clock);
        bus.A = a;
        bus.Enable = 1'b1;
        do begin
            @(posedge Clock); #1;
            cycles++;
            if (scramble && cycles == 20) bus.A = ~a;
        end while (!bus.done && cycles < 200);
        e = sb.pop_front();
        checks++;
        if (cycles !== 66) begin errors++; $display("FAIL %s latency: got %0d edges, expected 66", name, cycles); end
        checks++;
        if (bus.len !== e.len) begin errors++; $display("FAIL %s len: got %0d, expected %0d", name, bus.len, e.len); end
        checks++;
        if (bus.C !== e.c) begin errors++; $display("FAIL %s C: got %h, expected %h", name, bus.C, e.c); end
        checks++;
        if (bus.clipped !== e.clip) begin errors++; $display("FAIL %s clipped: got %b, expected %b", name, bus.clipped, e.clip); end
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL %s done_hold: got %b, expected 1", name, bus.done); end
        @(negedge Clock);
        bus.Enable = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done_release: got %b, expected 0", name, bus.done); end
        checks++;
        if (bus.C !== e.c || bus.len !== e.len) begin errors++; $display("FAIL %s keep_after_release: got len %0d, expected %0d", name, bus.len, e.len); end
        last_c = e.c;
        last_len = e.len;
    endtask

    task automatic test_reset();
        bus.Enable = 1'b0;
        bus.A = '0;
        reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (bus.C !== '0 || bus.len !== 7'd0 || bus.done !== 1'b0 || bus.clipped !== 1'b0) begin
            errors++;
            $display("FAIL reset: got len %0d done %b clipped %b, expected all zero", bus.len, bus.done, bus.clipped);
        end
        @(negedge Clock);
        reset = 1'b1;
    endtask

    function automatic logic [511:0] mixed_block();
        logic [511:0] b = '0;
        b[62 * 8 +: 8] = 8'hFD;
        b[47 * 8 +: 8] = 8'd10;
        return b;
    endfunction

    task automatic test_patterns();
        logic [511:0] b;
        encode('0, "all_zero", 1'b0);
        checks++;
        if (bus.C[7:0] !== 8'hC0 || bus.len !== 7'd1) begin errors++; $display("FAIL all_zero_const: got %h len %0d, expected c0 len 1", bus.C[7:0], bus.len); end
        b = '0;
        b[63 * 8 +: 8] = 8'd5;
        encode(b, "single", 1'b0);
        checks++;
        if (bus.C[15:0] !== 16'hBF05 || bus.len !== 7'd2) begin errors++; $display("FAIL single_const: got %h len %0d, expected bf05 len 2", bus.C[15:0], bus.len); end
        encode(mixed_block(), "mixed", 1'b0);
        checks++;
        if (bus.C[39:0] !== 40'hBC0A817D81 || bus.len !== 7'd5) begin errors++; $display("FAIL mixed_const: got %h len %0d, expected bc0a817d81 len 5", bus.C[39:0], bus.len); end
        encode({64{8'h01}}, "all_ones", 1'b0);
        checks++;
        if (bus.C !== {64{8'h01}} || bus.len !== 7'd64) begin errors++; $display("FAIL all_ones_const: got len %0d, expected 64", bus.len); end
    endtask

    task automatic test_clip();
        logic [511:0] b = '0;
        logic [15:0] want;
        b[63 * 8 +: 8] = 8'd100;
        b[62 * 8 +: 8] = 8'h9C;
`ifdef RLE_ENCODING_CLIP_EN
        want = 16'h4F4E;
`else
        want = 16'h1C64;
`endif
        encode(b, "clip", 1'b0);
        checks++;
        if (bus.C[15:0] !== want) begin errors++; $display("FAIL clip_const: got %h, expected %h", bus.C[15:0], want); end
    endtask

    task automatic test_reset_midscan();
        @(negedge Clock);
        bus.A = rand_block();
        bus.Enable = 1'b1;
        repeat (30) @(posedge Clock);
        @(negedge Clock);
        reset = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if (bus.C !== '0 || bus.len !== 7'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midscan: got len %0d done %b, expected 0 0", bus.len, bus.done);
        end
        @(negedge Clock);
        reset = 1'b1;
        bus.Enable = 1'b0;
        @(posedge Clock);
        encode(mixed_block(), "after_reset", 1'b0);
    endtask

    task automatic test_abort();
        logic [511:0] b = rand_block();
        @(negedge Clock);
        bus.A = b;
        bus.Enable = 1'b1;
        repeat (11) @(posedge Clock);
        @(negedge Clock);
        bus.Enable = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.C !== last_c || bus.len !== last_len) begin
            errors++;
            $display("FAIL abort: got done %b len %0d, expected done 0 len %0d", bus.done, bus.len, last_len);
        end
        encode(b, "restart", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) encode(rand_block(), "b2b", i[0]);
    endtask

    initial begin
        build_zigzag();
        test_reset();
        test_patterns();
        test_clip();
        test_reset_midscan();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
